// File: rtl/sram_output_reader.sv
// Streams one output row back from SRAM: issues sequential reads from the output
// base, absorbs the fixed read latency, and buffers returns in a credit-managed FIFO.
module sram_output_reader #(
    parameter int DATA_W     = 16,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              start,
    input  logic [12:0]       image_width,
    input  logic [25:0]       sram_outputAddrStart,
    output logic              sram_rd_en,
    output logic [25:0]       sram_addr,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              busy,
    output logic              done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + RD_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [12:0]            width_q, width_d;
    logic [12:0]            issue_cnt_q, issue_cnt_d;
    logic [12:0]            deliv_cnt_q, deliv_cnt_d;
    logic [25:0]            base_q, base_d;
    logic [RD_LATENCY-1:0]  vld_sr_q, vld_sr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       fifo_cnt_q, fifo_cnt_d;
    logic [CNT_W-1:0]       in_flight;
    logic [DATA_W-1:0]      mem_q [FIFO_DEPTH];
    logic                   issue, push, pop;

    // Outstanding reads are exactly the set bits of the latency shift register.
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            in_flight = in_flight + CNT_W'(vld_sr_q[i]);
        end
    end

    assign issue = (state_q == READ) && !clear &&
                   (({1'b0, in_flight} + {1'b0, fifo_cnt_q}) < (CNT_W + 1)'(FIFO_DEPTH));
    assign push  = vld_sr_q[RD_LATENCY-1];
    assign pop   = pix_valid && pix_ready;

    assign sram_rd_en = issue;
    assign sram_addr  = base_q + 26'(issue_cnt_q);
    assign pix_valid  = (fifo_cnt_q != '0);
    assign pix_data   = pix_valid ? mem_q[rd_ptr_q] : '0;
    assign busy       = (state_q == READ) || (state_q == DRAIN);
    assign done       = (state_q == DONE);

    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        base_d      = base_q;
        issue_cnt_d = issue_cnt_q;
        deliv_cnt_d = deliv_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_cnt_d  = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);

        vld_sr_d[0] = issue;
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_sr_d[i] = vld_sr_q[i-1];
        end

        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d    = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            deliv_cnt_d = deliv_cnt_q + 13'd1;
        end
        if (issue) begin
            issue_cnt_d = issue_cnt_q + 13'd1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    width_d     = image_width;
                    base_d      = sram_outputAddrStart;
                    issue_cnt_d = '0;
                    deliv_cnt_d = '0;
                    state_d     = (image_width == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (issue && (issue_cnt_q + 13'd1 == width_q)) state_d = DRAIN;
            end
            DRAIN: begin
                if (pop && (deliv_cnt_q + 13'd1 == width_q)) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over everything: late returns are dropped by zeroing the valid pipe.
        if (clear) begin
            state_d    = IDLE;
            vld_sr_d   = '0;
            fifo_cnt_d = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            width_q     <= '0;
            base_q      <= '0;
            issue_cnt_q <= '0;
            deliv_cnt_q <= '0;
            vld_sr_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
        end else begin
            if (push && !clear) begin
                assert (fifo_cnt_q < CNT_W'(FIFO_DEPTH));
            end
            state_q     <= state_d;
            width_q     <= width_d;
            base_q      <= base_d;
            issue_cnt_q <= issue_cnt_d;
            deliv_cnt_q <= deliv_cnt_d;
            vld_sr_q    <= vld_sr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
        end
    end

    // Buffer storage carries data only; occupancy is tracked by the control flops.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_q[wr_ptr_q] <= sram_rdata;
        end
    end

endmodule

// File: tb/tb_sram_output_reader.sv
// Bench for sram_output_reader: table rows, randomized rows against a queue-based
// reference model, and hand sequences for abort and asynchronous reset.
module tb_sram_output_reader;

    localparam int DATA_W     = 16;
    localparam int RD_LATENCY = 2;
    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic              start;
    logic [12:0]       image_width;
    logic [25:0]       sram_outputAddrStart;
    logic              sram_rd_en;
    logic [25:0]       sram_addr;
    logic [DATA_W-1:0] sram_rdata;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              busy;
    logic              done;

    int tests = 0;
    int fails = 0;

    sram_output_reader #(.DATA_W(DATA_W), .RD_LATENCY(RD_LATENCY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .clear(clear), .start(start),
        .image_width(image_width), .sram_outputAddrStart(sram_outputAddrStart),
        .sram_rd_en(sram_rd_en), .sram_addr(sram_addr), .sram_rdata(sram_rdata),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // SRAM contents are a fixed scramble of the address.
    function automatic logic [DATA_W-1:0] fdata(input logic [25:0] a);
        logic [15:0] m;
        m = a[15:0] * 16'h9E37;
        return m ^ {6'b0, a[25:16]};
    endfunction

    // SRAM model: address sampled at the issuing edge, data presented RD_LATENCY cycles on.
    logic [25:0] ap [RD_LATENCY];
    always @(posedge clk) begin
        ap[0] <= sram_addr;
        for (int i = 1; i < RD_LATENCY; i++) ap[i] <= ap[i-1];
    end
    assign sram_rdata = fdata(ap[RD_LATENCY-1]);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit rdy(input int c, input int stall, input bit rnd);
        if (c < stall) return 1'b0;
        if (rnd) return ($urandom_range(0, 3) != 0);
        return 1'b1;
    endfunction

    // Runs one row from the cycle after the call (start in cycle 0) and checks it.
    task automatic run_row(input logic [25:0] base, input logic [12:0] w, input int stall,
                           input bit rnd, input int exp_first, input int exp_done);
        int cyc = 0, done_cyc = -1, n_done = 0, first_rd = -1, first_px = -1, last_px = -1;
        int issued = 0, xfers = 0, max_out = 0, busy_bad = 0, hold_bad = 0;
        logic [25:0]       addrs[$];
        logic [DATA_W-1:0] pix[$];
        bit fin = 0, prev_stall = 0;
        logic [DATA_W-1:0] prev_data = '0;
        logic [25:0] ea;

        start = 1'b1;
        image_width = w;
        sram_outputAddrStart = base;
        pix_ready = rdy(0, stall, rnd);
        while (!fin && cyc < 400) begin
            @(negedge clk);
            if (prev_stall && (!pix_valid || pix_data !== prev_data)) hold_bad++;
            if (sram_rd_en) begin
                addrs.push_back(sram_addr);
                issued++;
                if (first_rd < 0) first_rd = cyc;
            end
            if (issued - xfers > max_out) max_out = issued - xfers;
            if (pix_valid && pix_ready) begin
                pix.push_back(pix_data);
                xfers++;
                if (first_px < 0) first_px = cyc;
                last_px = cyc;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                if (busy) busy_bad++;
                fin = 1;
            end else if (busy !== (cyc >= 1 && w != 0)) begin
                busy_bad++;
            end
            prev_stall = pix_valid && !pix_ready;
            prev_data  = pix_data;
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
            pix_ready = rdy(cyc, stall, rnd);
        end

        chk("row_finished", fin, 1);
        chk("done_cycle", done_cyc, (exp_done < 0) ? last_px + 1 : exp_done);
        chk("done_pulses", n_done, 1);
        chk("read_count", addrs.size(), w);
        for (int i = 0; i < addrs.size() && i < int'(w); i++) begin
            ea = base + 26'(i);
            chk("read_addr", addrs[i], ea);
        end
        if (w != 0) chk("first_read_cycle", first_rd, 1);
        chk("pixel_count", pix.size(), w);
        for (int i = 0; i < pix.size() && i < int'(w); i++) begin
            ea = base + 26'(i);
            chk("pixel_data", pix[i], fdata(ea));
        end
        if (exp_first >= 0) chk("first_pixel_cycle", first_px, exp_first);
        chk("outstanding_within_depth", (max_out <= FIFO_DEPTH), 1);
        chk("busy_profile", busy_bad, 0);
        chk("stall_hold", hold_bad, 0);
    endtask

    typedef struct {
        logic [25:0] base;
        logic [12:0] w;
        int          stall;
        int          exp_first;
        int          exp_done;
    } vec_t;

    initial begin
        vec_t tbl[6];
        int nx, cyc, late_bad;

        tbl[0] = '{26'h0000100, 13'd5,  0,  4,  9};
        tbl[1] = '{26'h3FFFFFE, 13'd4,  0,  4,  8};
        tbl[2] = '{26'h0000040, 13'd0,  0, -1,  1};
        tbl[3] = '{26'h0012345, 13'd12, 16, 16, 28};
        tbl[4] = '{26'h0002000, 13'd1,  0,  4,  5};
        tbl[5] = '{26'h3FFFFFF, 13'd3,  0,  4,  7};

        rst = 1'b1; clear = 1'b0; start = 1'b0; pix_ready = 1'b0;
        image_width = '0; sram_outputAddrStart = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rd_en", sram_rd_en, 0);
        chk("reset_addr", sram_addr, 0);
        chk("reset_pix_valid", pix_valid, 0);
        chk("reset_pix_data", pix_data, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back rows also prove a start is taken the cycle after done.
        for (int t = 0; t < 6; t++) begin
            run_row(tbl[t].base, tbl[t].w, tbl[t].stall, 1'b0, tbl[t].exp_first, tbl[t].exp_done);
        end

        for (int r = 0; r < 8; r++) begin
            run_row(26'($urandom), 13'($urandom_range(1, 20)), 0, 1'b1, -1, -1);
        end

        // Abort right after the third pixel transfer.
        start = 1'b1; image_width = 13'd8; sram_outputAddrStart = 26'h0001230; pix_ready = 1'b1;
        nx = 0; cyc = 0;
        while (nx < 3 && cyc < 50) begin
            @(negedge clk);
            if (pix_valid && pix_ready) nx++;
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
        end
        chk("abort_three_xfers", nx, 3);
        clear = 1'b1; pix_ready = 1'b0;
        @(posedge clk);
        #1;
        clear = 1'b0; pix_ready = 1'b1;
        @(negedge clk);
        chk("abort_idle_busy", busy, 0);
        chk("abort_pix_valid", pix_valid, 0);
        chk("abort_done", done, 0);
        late_bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (pix_valid || sram_rd_en || done) late_bad++;
        end
        chk("abort_no_late_data", late_bad, 0);
        @(posedge clk);
        #1;
        run_row(26'h0000400, 13'd2, 0, 1'b0, 4, 6);

        // Asynchronous reset in the middle of a read.
        start = 1'b1; image_width = 13'd10; sram_outputAddrStart = 26'h0000055; pix_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rd_en", sram_rd_en, 0);
        chk("async_addr", sram_addr, 0);
        chk("async_pix_valid", pix_valid, 0);
        chk("async_pix_data", pix_data, 0);
        chk("async_busy", busy, 0);
        chk("async_done", done, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        run_row(26'h0000777, 13'd3, 0, 1'b0, 4, 7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
